rvfi_trace_gen: RTL and testbench

- Producer side of the RVFI trace for multicycle in-order cores.
- Collects per-instruction events from core stages: fetch, operand read, memory access, and commit.
- Assembles them into one RVFI retirement packet per instruction on a single channel (NRET=1), with a monotonic rvfi_order.
- Output feeds the formal checkers and the trace dumper directly.

---
 rtl/rvfi_trace_gen_if.sv | 80 ++++++++
 rtl/rvfi_trace_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_rvfi_trace_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_trace_gen_if.sv
// rvfi_trace_gen_if: core-event and RVFI-packet signal bundle for rvfi_trace_gen.
//
// Handshake: every *_valid strobe is valid-only with no ready. The trace
// generator samples its payload on the rising clock edge where the strobe is
// high and never back-pressures. rvfi_valid is a one-cycle pulse that
// qualifies the rvfi_* packet fields.
//
// Modports:
//   master : core side. Drives f_/r_/m_/c_ events and observes rvfi_*.
//   slave  : trace generator. Consumes the events and drives rvfi_*.
// Optional: RVFI_TRACE_GEN_CSR_MISA_EN adds csr_misa_rdata (in) and
//           rvfi_csr_misa_rdata / rvfi_csr_misa_rmask (out).
interface rvfi_trace_gen_if #(
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int ORDER_W = 64
) ();
  localparam int MW = XLEN / 8;

  logic              f_valid;
  logic [XLEN-1:0]   f_pc;
  logic [ILEN-1:0]   f_insn;
  logic              f_intr;
  logic              r_valid;
  logic [4:0]        r_rs1_addr, r_rs2_addr;
  logic [XLEN-1:0]   r_rs1_rdata, r_rs2_rdata;
  logic              m_valid;
  logic [XLEN-1:0]   m_addr;
  logic [MW-1:0]     m_rmask, m_wmask;
  logic [XLEN-1:0]   m_rdata, m_wdata;
  logic              c_valid, c_trap, c_halt;
  logic [4:0]        c_rd_addr;
  logic [XLEN-1:0]   c_rd_wdata, c_pc_next;

  logic              rvfi_valid;
  logic [ORDER_W-1:0] rvfi_order;
  logic [ILEN-1:0]   rvfi_insn;
  logic [XLEN-1:0]   rvfi_pc_rdata, rvfi_pc_wdata;
  logic              rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]        rvfi_mode, rvfi_ixl;
  logic [4:0]        rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [XLEN-1:0]   rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [XLEN-1:0]   rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [MW-1:0]     rvfi_mem_rmask, rvfi_mem_wmask;
`ifdef RVFI_TRACE_GEN_CSR_MISA_EN
  logic [XLEN-1:0]   csr_misa_rdata, rvfi_csr_misa_rdata, rvfi_csr_misa_rmask;
`endif

  modport master (
`ifdef RVFI_TRACE_GEN_CSR_MISA_EN
    output csr_misa_rdata,
    input  rvfi_csr_misa_rdata, rvfi_csr_misa_rmask,
`endif
    output f_valid, f_pc, f_insn, f_intr,
    output r_valid, r_rs1_addr, r_rs2_addr, r_rs1_rdata, r_rs2_rdata,
    output m_valid, m_addr, m_rmask, m_wmask, m_rdata, m_wdata,
    output c_valid, c_trap, c_halt, c_rd_addr, c_rd_wdata, c_pc_next,
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
    input  rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl,
    input  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
    input  rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
    input  rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
  );

  modport slave (
`ifdef RVFI_TRACE_GEN_CSR_MISA_EN
    input  csr_misa_rdata,
    output rvfi_csr_misa_rdata, rvfi_csr_misa_rmask,
`endif
    input  f_valid, f_pc, f_insn, f_intr,
    input  r_valid, r_rs1_addr, r_rs2_addr, r_rs1_rdata, r_rs2_rdata,
    input  m_valid, m_addr, m_rmask, m_wmask, m_rdata, m_wdata,
    input  c_valid, c_trap, c_halt, c_rd_addr, c_rd_wdata, c_pc_next,
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
    output rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl,
    output rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
    output rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
    output rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
  );
endinterface

// File: rtl/rvfi_trace_gen.sv
// rvfi_trace_gen: assembles fetch / operand-read / memory / commit events of a
// multicycle in-order core into one RVFI retirement packet per instruction
// (NRET=1) with a monotonically increasing rvfi_order.
//
// Ports:
//   clock, reset : clock; synchronous active-low reset.
//   bus          : rvfi_trace_gen_if.slave (core events in, rvfi_* out).
//   proto_err    : sticky flag for out-of-order / unexpected events.
//   dbg_state    : current FSM state (0 IDLE, 1 ACTIVE, 2 EMIT, 3 HALTED).
// Optional: RVFI_TRACE_GEN_CSR_MISA_EN adds the misa CSR trace fields.
module rvfi_trace_gen #(
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int ORDER_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  rvfi_trace_gen_if.slave  bus,
  output logic             proto_err,
  output logic [1:0]       dbg_state
);
  localparam int MW = XLEN / 8;
  localparam logic [1:0] IXL = (XLEN == 64) ? 2'd2 : 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EMIT, S_HALTED} state_t;
  state_t state;

  logic [ORDER_W-1:0] order_cnt;

  // Shadow copy of the instruction being assembled.
  logic [XLEN-1:0] sh_pc, nx_pc;
  logic [ILEN-1:0] sh_insn, nx_insn;
  logic            sh_intr, nx_intr;
  logic [4:0]      sh_rs1_addr, sh_rs2_addr, nx_rs1_addr, nx_rs2_addr;
  logic [XLEN-1:0] sh_rs1_rdata, sh_rs2_rdata, nx_rs1_rdata, nx_rs2_rdata;
  logic [XLEN-1:0] sh_mem_addr, sh_mem_rdata, sh_mem_wdata;
  logic [XLEN-1:0] nx_mem_addr, nx_mem_rdata, nx_mem_wdata;
  logic [MW-1:0]   sh_mem_rmask, sh_mem_wmask, nx_mem_rmask, nx_mem_wmask;

  logic            fetch_take, r_take, m_take, c_take, proto_hit;
  logic [MW-1:0]   cm_wmask;
  logic [XLEN-1:0] cm_wdata, cm_rd_wdata;
  logic [4:0]      cm_rd_addr;

  assign dbg_state = state;

  always_comb begin
    // A fetch in EMIT is still accepted so back-to-back retirement loses
    // nothing; once a halting packet is out, everything is ignored.
    fetch_take = bus.f_valid &&
                 ((state == S_IDLE) || (state == S_EMIT && !bus.rvfi_halt));
    r_take = bus.r_valid && (state == S_ACTIVE || fetch_take);
    m_take = bus.m_valid && (state == S_ACTIVE || fetch_take);
    c_take = bus.c_valid && (state == S_ACTIVE || (state == S_IDLE && bus.f_valid));

    case (state)
      S_IDLE:   proto_hit = !bus.f_valid && (bus.r_valid || bus.m_valid || bus.c_valid);
      S_ACTIVE: proto_hit = bus.f_valid;
      S_EMIT:   proto_hit = !bus.rvfi_halt &&
                            (bus.f_valid || bus.r_valid || bus.m_valid || bus.c_valid);
      default:  proto_hit = 1'b0;
    endcase

    nx_pc        = sh_pc;
    nx_insn      = sh_insn;
    nx_intr      = sh_intr;
    nx_rs1_addr  = sh_rs1_addr;
    nx_rs2_addr  = sh_rs2_addr;
    nx_rs1_rdata = sh_rs1_rdata;
    nx_rs2_rdata = sh_rs2_rdata;
    nx_mem_addr  = sh_mem_addr;
    nx_mem_rmask = sh_mem_rmask;
    nx_mem_wmask = sh_mem_wmask;
    nx_mem_rdata = sh_mem_rdata;
    nx_mem_wdata = sh_mem_wdata;

    if (fetch_take) begin
      nx_pc        = bus.f_pc;
      nx_insn      = bus.f_insn;
      nx_intr      = bus.f_intr;
      nx_rs1_addr  = '0;
      nx_rs2_addr  = '0;
      nx_rs1_rdata = '0;
      nx_rs2_rdata = '0;
      nx_mem_addr  = '0;
      nx_mem_rmask = '0;
      nx_mem_wmask = '0;
      nx_mem_rdata = '0;
      nx_mem_wdata = '0;
    end
    if (r_take) begin
      nx_rs1_addr  = bus.r_rs1_addr;
      nx_rs2_addr  = bus.r_rs2_addr;
      nx_rs1_rdata = (bus.r_rs1_addr == 5'd0) ? '0 : bus.r_rs1_rdata;
      nx_rs2_rdata = (bus.r_rs2_addr == 5'd0) ? '0 : bus.r_rs2_rdata;
    end
    if (m_take) begin
      nx_mem_addr  = bus.m_addr;
      nx_mem_rmask = bus.m_rmask;
      nx_mem_wmask = bus.m_wmask;
      nx_mem_rdata = (bus.m_rmask == '0) ? '0 : bus.m_rdata;
      nx_mem_wdata = (bus.m_wmask == '0) ? '0 : bus.m_wdata;
    end

    // A trapping instruction architecturally writes neither rd nor memory.
    cm_wmask    = bus.c_trap ? '0 : nx_mem_wmask;
    cm_wdata    = (cm_wmask == '0) ? '0 : nx_mem_wdata;
    cm_rd_addr  = bus.c_trap ? 5'd0 : bus.c_rd_addr;
    cm_rd_wdata = (bus.c_trap || bus.c_rd_addr == 5'd0) ? '0 : bus.c_rd_wdata;
  end

`ifdef RVFI_TRACE_GEN_CSR_MISA_EN
  // SYSTEM opcode, Zicsr funct3, csr 0x301; csrrw/csrrwi with rd=0 does not read.
  logic misa_read;
  assign misa_read = (nx_insn[6:0] == 7'h73) && (nx_insn[14:12] != 3'b000) &&
                     (nx_insn[14:12] != 3'b100) && (nx_insn[31:20] == 12'h301) &&
                     !((nx_insn[13:12] == 2'b01) && (nx_insn[11:7] == 5'd0));
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= S_IDLE;
      order_cnt          <= '0;
      proto_err          <= 1'b0;
      sh_pc              <= '0;
      sh_insn            <= '0;
      sh_intr            <= 1'b0;
      sh_rs1_addr        <= '0;
      sh_rs2_addr        <= '0;
      sh_rs1_rdata       <= '0;
      sh_rs2_rdata       <= '0;
      sh_mem_addr        <= '0;
      sh_mem_rmask       <= '0;
      sh_mem_wmask       <= '0;
      sh_mem_rdata       <= '0;
      sh_mem_wdata       <= '0;
      bus.rvfi_valid     <= 1'b0;
      bus.rvfi_order     <= '0;
      bus.rvfi_insn      <= '0;
      bus.rvfi_pc_rdata  <= '0;
      bus.rvfi_pc_wdata  <= '0;
      bus.rvfi_trap      <= 1'b0;
      bus.rvfi_halt      <= 1'b0;
      bus.rvfi_intr      <= 1'b0;
      bus.rvfi_mode      <= 2'b00;
      bus.rvfi_ixl       <= 2'b00;
      bus.rvfi_rs1_addr  <= '0;
      bus.rvfi_rs2_addr  <= '0;
      bus.rvfi_rs1_rdata <= '0;
      bus.rvfi_rs2_rdata <= '0;
      bus.rvfi_rd_addr   <= '0;
      bus.rvfi_rd_wdata  <= '0;
      bus.rvfi_mem_addr  <= '0;
      bus.rvfi_mem_rmask <= '0;
      bus.rvfi_mem_wmask <= '0;
      bus.rvfi_mem_rdata <= '0;
      bus.rvfi_mem_wdata <= '0;
`ifdef RVFI_TRACE_GEN_CSR_MISA_EN
      bus.rvfi_csr_misa_rdata <= '0;
      bus.rvfi_csr_misa_rmask <= '0;
`endif
    end else begin
      bus.rvfi_mode  <= 2'b11;
      bus.rvfi_ixl   <= IXL;
      bus.rvfi_valid <= 1'b0;
      if (proto_hit) proto_err <= 1'b1;

      sh_pc        <= nx_pc;
      sh_insn      <= nx_insn;
      sh_intr      <= nx_intr;
      sh_rs1_addr  <= nx_rs1_addr;
      sh_rs2_addr  <= nx_rs2_addr;
      sh_rs1_rdata <= nx_rs1_rdata;
      sh_rs2_rdata <= nx_rs2_rdata;
      sh_mem_addr  <= nx_mem_addr;
      sh_mem_rmask <= nx_mem_rmask;
      sh_mem_wmask <= nx_mem_wmask;
      sh_mem_rdata <= nx_mem_rdata;
      sh_mem_wdata <= nx_mem_wdata;

      case (state)
        S_IDLE:   if (bus.f_valid) state <= bus.c_valid ? S_EMIT : S_ACTIVE;
        S_ACTIVE: if (bus.c_valid) state <= S_EMIT;
        S_EMIT: begin
          if (bus.rvfi_halt)    state <= S_HALTED;
          else if (bus.f_valid) state <= S_ACTIVE;
          else                  state <= S_IDLE;
        end
        default: state <= S_HALTED;
      endcase

      // Packet registers load only on the edge that enters EMIT.
      if (c_take) begin
        bus.rvfi_valid     <= 1'b1;
        bus.rvfi_order     <= order_cnt;
        order_cnt          <= order_cnt + ORDER_W'(1);
        bus.rvfi_insn      <= nx_insn;
        bus.rvfi_pc_rdata  <= nx_pc;
        bus.rvfi_pc_wdata  <= bus.c_pc_next;
        bus.rvfi_trap      <= bus.c_trap;
        bus.rvfi_halt      <= bus.c_halt;
        bus.rvfi_intr      <= nx_intr;
        bus.rvfi_rs1_addr  <= nx_rs1_addr;
        bus.rvfi_rs2_addr  <= nx_rs2_addr;
        bus.rvfi_rs1_rdata <= nx_rs1_rdata;
        bus.rvfi_rs2_rdata <= nx_rs2_rdata;
        bus.rvfi_rd_addr   <= cm_rd_addr;
        bus.rvfi_rd_wdata  <= cm_rd_wdata;
        bus.rvfi_mem_addr  <= nx_mem_addr;
        bus.rvfi_mem_rmask <= nx_mem_rmask;
        bus.rvfi_mem_wmask <= cm_wmask;
        bus.rvfi_mem_rdata <= nx_mem_rdata;
        bus.rvfi_mem_wdata <= cm_wdata;
`ifdef RVFI_TRACE_GEN_CSR_MISA_EN
        bus.rvfi_csr_misa_rdata <= bus.csr_misa_rdata;
        bus.rvfi_csr_misa_rmask <= misa_read ? '1 : '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_rvfi_trace_gen.sv
module tb_rvfi_trace_gen;
  logic       clock;
  logic       reset;
  logic       proto_err;
  logic [1:0] dbg_state;

  rvfi_trace_gen_if #(.XLEN(32), .ILEN(32), .ORDER_W(64)) bus ();

  rvfi_trace_gen #(.XLEN(32), .ILEN(32), .ORDER_W(64)) dut (
    .clock(clock), .reset(reset), .bus(bus), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- types ----------------
  typedef struct {
    logic [31:0] pc, insn; logic intr;
    logic [4:0]  rs1, rs2; logic [31:0] rs1_d, rs2_d;
    logic [31:0] maddr; logic [3:0] rmask, wmask; logic [31:0] mrdata, mwdata;
    logic trap, halt; logic [4:0] rd; logic [31:0] rd_d, next;
  } insn_t;

  typedef struct packed {
    logic [63:0] order; logic [31:0] insn, pc_r, pc_w; logic trap, halt, intr;
    logic [4:0] rs1a, rs2a; logic [31:0] rs1d, rs2d; logic [4:0] rda; logic [31:0] rdd;
    logic [31:0] maddr; logic [3:0] rmask, wmask; logic [31:0] mrd, mwd;
  } pkt_t;
  localparam int PKT_W = $bits(pkt_t);

  typedef struct {
    insn_t t; int lc, rs, ms;
    logic [31:0] e_rs1d, e_rdd, e_pcw, e_mrd, e_mwd; logic [4:0] e_rda; logic [3:0] e_wmask; logic e_trap;
  } vec_t;

  // ---------------- scoreboard state ----------------
  logic [PKT_W-1:0] exp_q[$];
  logic [63:0]      exp_order;
  logic             exp_perr;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a retired packet follows from the instruction's events by the
  // sanitisation rules alone.
  function automatic pkt_t model(input insn_t t, input bit has_r, input bit has_m, input logic [63:0] ord);
    pkt_t p;
    p = '0;
    p.order = ord; p.insn = t.insn; p.pc_r = t.pc; p.pc_w = t.next;
    p.trap = t.trap; p.halt = t.halt; p.intr = t.intr;
    if (has_r) begin
      p.rs1a = t.rs1; p.rs1d = (t.rs1 == 0) ? 32'h0 : t.rs1_d;
      p.rs2a = t.rs2; p.rs2d = (t.rs2 == 0) ? 32'h0 : t.rs2_d;
    end
    if (has_m) begin
      p.maddr = t.maddr; p.rmask = t.rmask;
      p.mrd = (t.rmask == 0) ? 32'h0 : t.mrdata;
      p.wmask = t.trap ? 4'h0 : t.wmask;
      p.mwd = (p.wmask == 0) ? 32'h0 : t.mwdata;
    end
    p.rda = t.trap ? 5'd0 : t.rd;
    p.rdd = (t.trap || t.rd == 0) ? 32'h0 : t.rd_d;
    return p;
  endfunction

  function automatic pkt_t dut_pkt();
    pkt_t p;
    p.order = bus.rvfi_order; p.insn = bus.rvfi_insn; p.pc_r = bus.rvfi_pc_rdata;
    p.pc_w = bus.rvfi_pc_wdata; p.trap = bus.rvfi_trap; p.halt = bus.rvfi_halt;
    p.intr = bus.rvfi_intr; p.rs1a = bus.rvfi_rs1_addr; p.rs2a = bus.rvfi_rs2_addr;
    p.rs1d = bus.rvfi_rs1_rdata; p.rs2d = bus.rvfi_rs2_rdata; p.rda = bus.rvfi_rd_addr;
    p.rdd = bus.rvfi_rd_wdata; p.maddr = bus.rvfi_mem_addr; p.rmask = bus.rvfi_mem_rmask;
    p.wmask = bus.rvfi_mem_wmask; p.mrd = bus.rvfi_mem_rdata; p.mwd = bus.rvfi_mem_wdata;
    return p;
  endfunction

  // Monitor: every retirement pulse must match the oldest expected packet.
  always @(negedge clock) begin
    if (reset && bus.rvfi_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got order %0h expected no pulse", bus.rvfi_order);
      end else begin
        logic [PKT_W-1:0] e;
        e = exp_q.pop_front();
        if (dut_pkt() !== pkt_t'(e)) begin
          errors++;
          $display("FAIL packet: got %h expected %h", dut_pkt(), e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_strobes();
    bus.f_valid = 1'b0; bus.r_valid = 1'b0; bus.m_valid = 1'b0; bus.c_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_strobes();
    tick();
    tick();
    exp_q.delete();
    exp_order = '0;
    exp_perr  = 1'b0;
    reset = 1'b1;
  endtask

  // Fetch at cycle 0, reads at rs, memory at ms, a stale read at js (< rs)
  // that must be overwritten, commit at lc. Returns in the EMIT cycle.
  task automatic drive_insn(input insn_t t, input int lc, input int rs, input int ms, input int js);
    for (int c = 0; c <= lc; c++) begin
      clear_strobes();
      if (c == 0) begin
        bus.f_valid = 1'b1; bus.f_pc = t.pc; bus.f_insn = t.insn; bus.f_intr = t.intr;
      end
      if (c == js) begin
        bus.r_valid = 1'b1; bus.r_rs1_addr = 5'($urandom); bus.r_rs2_addr = 5'($urandom);
        bus.r_rs1_rdata = $urandom; bus.r_rs2_rdata = $urandom;
      end
      if (c == rs) begin
        bus.r_valid = 1'b1; bus.r_rs1_addr = t.rs1; bus.r_rs2_addr = t.rs2;
        bus.r_rs1_rdata = t.rs1_d; bus.r_rs2_rdata = t.rs2_d;
      end
      if (c == ms) begin
        bus.m_valid = 1'b1; bus.m_addr = t.maddr; bus.m_rmask = t.rmask; bus.m_wmask = t.wmask;
        bus.m_rdata = t.mrdata; bus.m_wdata = t.mwdata;
      end
      if (c == lc) begin
        bus.c_valid = 1'b1; bus.c_trap = t.trap; bus.c_halt = t.halt;
        bus.c_rd_addr = t.rd; bus.c_rd_wdata = t.rd_d; bus.c_pc_next = t.next;
        exp_q.push_back(model(t, rs >= 0, ms >= 0, exp_order));
        exp_order++;
      end
      if (c == 0 && dbg_state == 2'd2) exp_perr = 1'b1;
      tick();
    end
    clear_strobes();
  endtask

  function automatic insn_t mk(input logic [31:0] pc, insn, input logic [4:0] rs1, input logic [31:0] rs1_d,
                               input logic [31:0] maddr, input logic [3:0] rmask, input logic [31:0] mrdata,
                               input logic [3:0] wmask, input logic [31:0] mwdata, input logic trap,
                               input logic [4:0] rd, input logic [31:0] rd_d, next);
    insn_t t;
    t.pc = pc; t.insn = insn; t.intr = 1'b0; t.rs1 = rs1; t.rs1_d = rs1_d; t.rs2 = 5'd0; t.rs2_d = 32'h0;
    t.maddr = maddr; t.rmask = rmask; t.mrdata = mrdata; t.wmask = wmask; t.mwdata = mwdata;
    t.trap = trap; t.halt = 1'b0; t.rd = rd; t.rd_d = rd_d; t.next = next;
    return t;
  endfunction

  function automatic insn_t rand_insn();
    insn_t t;
    t.pc = $urandom & 32'hFFFF_FFFC; t.insn = $urandom; t.intr = 1'($urandom_range(0, 1));
    t.rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.rs2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.rs1_d = $urandom; t.rs2_d = $urandom; t.maddr = $urandom;
    t.rmask = 4'($urandom_range(0, 15)); t.wmask = 4'($urandom_range(0, 15));
    t.mrdata = $urandom; t.mwdata = $urandom;
    t.trap = ($urandom_range(0, 7) == 0); t.halt = 1'b0;
    t.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.rd_d = $urandom; t.next = $urandom & 32'hFFFF_FFFC;
    return t;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[5];

  initial begin
    vecs[0] = '{mk(32'h100, 32'h00500093, 5'd0, 32'h55, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd1, 32'h5, 32'h104),
                2, 1, -1, 32'h0, 32'h5, 32'h104, 32'h0, 32'h0, 5'd1, 4'h0, 1'b0};
    vecs[1] = '{mk(32'h104, 32'h00012183, 5'd2, 32'h2000, 32'h2000, 4'hF, 32'hDEADBEEF, 4'h0, 32'h1234, 1'b0, 5'd3, 32'hDEADBEEF, 32'h108),
                3, 1, 2, 32'h2000, 32'hDEADBEEF, 32'h108, 32'hDEADBEEF, 32'h0, 5'd3, 4'h0, 1'b0};
    vecs[2] = '{mk(32'h108, 32'h00f12023, 5'd0, 32'h0, 32'h3000, 4'h0, 32'h77, 4'hF, 32'hCAFE, 1'b1, 5'd5, 32'h7, 32'h80),
                2, -1, 2, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0, 5'd0, 4'h0, 1'b1};
    vecs[3] = '{mk(32'h10c, 32'h00120313, 5'd4, 32'h9, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd6, 32'h11, 32'h110),
                0, 0, -1, 32'h9, 32'h11, 32'h110, 32'h0, 32'h0, 5'd6, 4'h0, 1'b0};
    vecs[4] = '{mk(32'h110, 32'h00000013, 5'd7, 32'h42, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h99, 32'h114),
                1, 1, -1, 32'h42, 32'h0, 32'h114, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0};

    // Reset state, sampled while reset is held.
    reset = 1'b0;
    clear_strobes();
    bus.f_pc = '0; bus.f_insn = '0; bus.f_intr = 1'b0;
    bus.r_rs1_addr = '0; bus.r_rs2_addr = '0; bus.r_rs1_rdata = '0; bus.r_rs2_rdata = '0;
    bus.m_addr = '0; bus.m_rmask = '0; bus.m_wmask = '0; bus.m_rdata = '0; bus.m_wdata = '0;
    bus.c_trap = 1'b0; bus.c_halt = 1'b0; bus.c_rd_addr = '0; bus.c_rd_wdata = '0; bus.c_pc_next = '0;
    tick();
    tick();
    chk("reset_valid", 64'(bus.rvfi_valid), 64'h0);
    chk("reset_order", bus.rvfi_order, 64'h0);
    chk("reset_pc_wdata", 64'(bus.rvfi_pc_wdata), 64'h0);
    chk("reset_mode", 64'(bus.rvfi_mode), 64'h0);
    chk("reset_proto_err", 64'(proto_err), 64'h0);
    do_reset();
    tick();
    chk("mode_after_reset", 64'(bus.rvfi_mode), 64'h3);
    chk("ixl_after_reset", 64'(bus.rvfi_ixl), 64'h1);

    // Table-driven directed vectors, with an idle cycle between instructions.
    for (int i = 0; i < 5; i++) begin
      drive_insn(vecs[i].t, vecs[i].lc, vecs[i].rs, vecs[i].ms, -1);
      chk($sformatf("v%0d_valid", i), 64'(bus.rvfi_valid), 64'h1);
      chk($sformatf("v%0d_order", i), bus.rvfi_order, 64'(i));
      chk($sformatf("v%0d_rs1_rdata", i), 64'(bus.rvfi_rs1_rdata), 64'(vecs[i].e_rs1d));
      chk($sformatf("v%0d_rd_addr", i), 64'(bus.rvfi_rd_addr), 64'(vecs[i].e_rda));
      chk($sformatf("v%0d_rd_wdata", i), 64'(bus.rvfi_rd_wdata), 64'(vecs[i].e_rdd));
      chk($sformatf("v%0d_pc_wdata", i), 64'(bus.rvfi_pc_wdata), 64'(vecs[i].e_pcw));
      chk($sformatf("v%0d_mem_rdata", i), 64'(bus.rvfi_mem_rdata), 64'(vecs[i].e_mrd));
      chk($sformatf("v%0d_mem_wmask", i), 64'(bus.rvfi_mem_wmask), 64'(vecs[i].e_wmask));
      chk($sformatf("v%0d_mem_wdata", i), 64'(bus.rvfi_mem_wdata), 64'(vecs[i].e_mwd));
      chk($sformatf("v%0d_trap", i), 64'(bus.rvfi_trap), 64'(vecs[i].e_trap));
      tick();
      chk($sformatf("v%0d_pulse_end", i), 64'(bus.rvfi_valid), 64'h0);
    end
    chk("table_proto_err", 64'(proto_err), 64'h0);

    // Three back-to-back instructions, each next fetch landing in EMIT.
    do_reset();
    drive_insn(rand_insn(), 1, 1, -1, -1);
    chk("b2b_perr_before_overlap", 64'(proto_err), 64'h0);
    drive_insn(rand_insn(), 1, 0, 1, -1);
    chk("b2b_perr_after_overlap", 64'(proto_err), 64'h1);
    drive_insn(rand_insn(), 2, 1, 2, -1);
    chk("b2b_third_order", bus.rvfi_order, 64'h2);
    tick();

    // Commit while idle: ignored, sticky error until reset.
    do_reset();
    tick();
    bus.c_valid = 1'b1; bus.c_rd_addr = 5'd3; bus.c_rd_wdata = 32'h1;
    tick();
    clear_strobes();
    chk("idle_commit_perr", 64'(proto_err), 64'h1);
    chk("idle_commit_no_pulse", 64'(bus.rvfi_valid), 64'h0);
    tick(); tick(); tick();
    chk("idle_commit_perr_sticky", 64'(proto_err), 64'h1);
    do_reset();
    chk("perr_cleared_by_reset", 64'(proto_err), 64'h0);

    // Reset while an instruction is being assembled.
    tick();
    bus.f_valid = 1'b1; bus.f_pc = 32'h200; bus.f_insn = 32'h13;
    tick();
    clear_strobes();
    bus.r_valid = 1'b1; bus.r_rs1_addr = 5'd1; bus.r_rs1_rdata = 32'h5;
    tick();
    clear_strobes();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midreset_no_pulse", 64'(bus.rvfi_valid), 64'h0);
    chk("midreset_state_idle", 64'(dbg_state), 64'h0);
    tick();
    drive_insn(rand_insn(), 2, 1, 1, -1);
    chk("midreset_next_order", bus.rvfi_order, 64'h0);
    tick();

    // Halting instruction: afterwards everything is ignored silently.
    do_reset();
    begin
      insn_t h;
      h = rand_insn();
      h.halt = 1'b1;
      drive_insn(h, 1, 1, -1, -1);
    end
    chk("halt_flag", 64'(bus.rvfi_halt), 64'h1);
    tick();
    chk("halted_state", 64'(dbg_state), 64'h3);
    bus.f_valid = 1'b1; bus.c_valid = 1'b1; bus.r_valid = 1'b1;
    tick();
    clear_strobes();
    tick(); tick();
    chk("halted_no_perr", 64'(proto_err), 64'h0);

    // Randomized instructions against the reference model.
    do_reset();
    begin
      bit b2b;
      b2b = 1'b0;
      for (int n = 0; n < 200; n++) begin
        int lc, rs, ms, js;
        lc = b2b ? $urandom_range(1, 4) : $urandom_range(0, 4);
        rs = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, lc);
        ms = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, lc);
        js = (rs > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, rs - 1) : -1;
        drive_insn(rand_insn(), lc, rs, ms, js);
        chk("rand_proto_err", 64'(proto_err), 64'(exp_perr));
        b2b = 1'($urandom_range(0, 1));
        if (!b2b) repeat ($urandom_range(1, 3)) tick();
      end
    end
    tick(); tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
